// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller. It computes one product over up to four cycles
// through a single shared 4x4 multiplier and accumulates the partial products into a 16-bit result.
module mult8x8_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_r,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  step;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc, r_q;
  logic [15:0] prod_sh, acc_sum;
  logic [2:0]  first_step, next_step;
  logic        accept;

  // Step bit 1 selects the high nibble of A, and step bit 0 selects the high nibble of B.
  function automatic logic [3:0] nib_a(input logic [7:0] x, input logic [1:0] s);
    return s[1] ? x[7:4] : x[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] y, input logic [1:0] s);
    return s[0] ? y[7:4] : y[3:0];
  endfunction

  function automatic logic step_on(input logic [7:0] x, input logic [7:0] y, input logic [1:0] s);
    return !SKIP_ZERO || (nib_a(x, s) != 4'h0 && nib_b(y, s) != 4'h0);
  endfunction

  // Returns the first active step at or after 'from'. A value of 4 means no step remains.
  function automatic logic [2:0] find_step(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] from);
    logic [2:0] res;
    res = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (3'(i) >= from && step_on(x, y, 2'(i))) res = 3'(i);
    return res;
  endfunction

  assign in_ready   = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state == DONE);
  assign busy       = (state == CALC);
  assign r          = r_q;
  assign mul_a      = busy ? nib_a(a_q, step) : 4'h0;
  assign mul_b      = busy ? nib_b(b_q, step) : 4'h0;
  assign first_step = find_step(a, b, 3'd0);
  assign next_step  = find_step(a_q, b_q, {1'b0, step} + 3'd1);

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prod_sh = {4'h0, mul_r, 4'h0};
    case (step)
      2'd0:    prod_sh = {8'h00, mul_r};
      2'd3:    prod_sh = {mul_r, 8'h00};
      default: prod_sh = {4'h0, mul_r, 4'h0};
    endcase
  end

  assign acc_sum = acc + prod_sh;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      acc   <= 16'h0000;
      r_q   <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q <= a;
            b_q <= b;
            acc <= 16'h0000;
            if (first_step[2]) begin
              state <= DONE;
              step  <= 2'd0;
              r_q   <= 16'h0000;
            end else begin
              state <= CALC;
              step  <= first_step[1:0];
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (next_step[2]) begin
            state <= DONE;
            step  <= 2'd0;
            r_q   <= acc_sum;
          end else begin
            step <= next_step[1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl. One instance runs with SKIP_ZERO=0 and is checked against a
// scoreboard. A second instance runs with SKIP_ZERO=1 and is checked with hand-written latency sequences.
module tb_mult8x8_seq_ctrl;

  logic clk, rst_n;
  int   cyc;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0, force_ff;
  logic [7:0]  a0, b0, mul_r0;
  logic [3:0]  mul_a0, mul_b0;
  logic [15:0] r0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [7:0]  a1, b1, mul_r1;
  logic [3:0]  mul_a1, mul_b1;
  logic [15:0] r1;

  int          n_vec, n_err, last_acc;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    int          lat;
  } skip_vec_t;

  mult8x8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .r(r0), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_r(mul_r0), .busy(busy0));

  mult8x8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .r(r1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_r(mul_r1), .busy(busy1));

  assign mul_r0 = force_ff ? 8'hFF : {4'h0, mul_a0} * {4'h0, mul_b0};
  assign mul_r1 = {4'h0, mul_a1} * {4'h0, mul_b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // Scoreboard: each result handshake pops the oldest expected product.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      if (exp_q.size() == 0) fail("unexpected_result");
      else check("result_r", r0, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] texp,
                      input bit push);
    int n;
    n = 0;
    in_valid0 = 1'b1;
    a0 = ta;
    b0 = tb;
    @(negedge clk);
    while (!in_ready0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) fail("accept_timeout");
    else begin
      @(posedge clk);
      if (push) exp_q.push_back(texp);
      last_acc = cyc;
      #1;
    end
    in_valid0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input skip_vec_t v);
    int n;
    in_valid1 = 1'b1;
    a1 = v.a;
    b1 = v.b;
    @(negedge clk);
    check("skip_in_ready", 16'(in_ready1), 16'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("skip_latency", 16'(n), 16'(v.lat));
    check("skip_r", r1, v.r);
    @(posedge clk);
    #1;
  endtask

  vec_t      tbl[6];
  skip_vec_t stbl[5];
  logic [3:0] exp_ma[4];
  logic [3:0] exp_mb[4];
  int         t_ff;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; last_acc = 0; force_ff = 1'b0;
    rst_n = 1'b0;
    in_valid0 = 1'b0; a0 = 8'h00; b0 = 8'h00; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = 8'h00; b1 = 8'h00; out_ready1 = 1'b1;

    tbl[0] = '{8'h80, 8'h02, 16'h0100};
    tbl[1] = '{8'h0A, 8'h0B, 16'h006E};
    tbl[2] = '{8'hA5, 8'h5A, 16'h3A02};
    tbl[3] = '{8'h0F, 8'hF0, 16'h0E10};
    tbl[4] = '{8'h01, 8'h01, 16'h0001};
    tbl[5] = '{8'h00, 8'h00, 16'h0000};

    stbl[0] = '{8'h30, 8'h05, 16'h00F0, 1};
    stbl[1] = '{8'h00, 8'h00, 16'h0000, 0};
    stbl[2] = '{8'h12, 8'h30, 16'h0360, 2};
    stbl[3] = '{8'h12, 8'h34, 16'h03A8, 4};
    stbl[4] = '{8'h10, 8'h01, 16'h0010, 1};

    exp_ma = '{4'h2, 4'h2, 4'h1, 4'h1};
    exp_mb = '{4'h4, 4'h3, 4'h4, 4'h3};

    // Check the outputs while reset is held.
    #3;
    check("rst_in_ready", 16'(in_ready0), 16'd0);
    check("rst_out_valid", 16'(out_valid0), 16'd0);
    check("rst_r", r0, 16'h0000);
    check("rst_mul", {8'h00, mul_a0, mul_b0}, 16'h0000);
    check("rst_busy", 16'(busy0), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 16'(in_ready0), 16'd1);
    @(posedge clk);
    #1;

    // Check the first operation's latency and the order in which nibbles reach the multiplier.
    send(8'h12, 8'h34, 16'h03A8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_mul_a", 16'(mul_a0), 16'(exp_ma[i]));
      check("seq_mul_b", 16'(mul_b0), 16'(exp_mb[i]));
      check("seq_busy", 16'(busy0), 16'd1);
      check("seq_in_ready", 16'(in_ready0), 16'd0);
      check("seq_out_valid_low", 16'(out_valid0), 16'd0);
    end
    @(negedge clk);
    check("seq_out_valid_high", 16'(out_valid0), 16'd1);
    check("seq_mul_idle", {8'h00, mul_a0, mul_b0}, 16'h0000);
    @(negedge clk);
    check("seq_out_valid_1cyc", 16'(out_valid0), 16'd0);
    check("seq_r_hold", r0, 16'h03A8);
    @(posedge clk);
    #1;

    // Issue back-to-back accepts while the previous result is in DONE.
    send(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    t_ff = last_acc;
    send(8'h00, 8'h07, 16'h0000, 1'b1);
    check("b2b_spacing", 16'(last_acc - t_ff), 16'd5);
    for (int i = 0; i < 6; i++) send(tbl[i].a, tbl[i].b, tbl[i].r, 1'b1);
    drain();

    // Hold off the result with backpressure while a new request waits.
    out_ready0 = 1'b0;
    send(8'h03, 8'h05, 16'h000F, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid0 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!out_valid0) fail("bp_out_valid_timeout");
    end
    in_valid0 = 1'b1;
    a0 = 8'h11;
    b0 = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_out_valid", 16'(out_valid0), 16'd1);
      check("bp_r", r0, 16'h000F);
      check("bp_in_ready", 16'(in_ready0), 16'd0);
    end
    @(posedge clk);
    #1 out_ready0 = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 16'(in_ready0), 16'd1);
    @(posedge clk);
    exp_q.push_back(16'h0121);
    #1 in_valid0 = 1'b0;
    check("bp_accepted", 16'(busy0), 16'd1);
    drain();

    // Force every partial product to 8'hFF so the accumulator wraps.
    force_ff = 1'b1;
    send(8'hFF, 8'hFF, 16'h1FDF, 1'b1);
    drain();
    force_ff = 1'b0;

    // Run SKIP_ZERO=1 cases with variable latency.
    for (int i = 0; i < 5; i++) run1(stbl[i]);

    // Assert reset asynchronously in the middle of an operation, during step 2.
    send(8'h12, 8'h34, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("midrst_step2", {8'h00, mul_a0, mul_b0}, 16'h0014);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid0), 16'd0);
    check("midrst_r", r0, 16'h0000);
    check("midrst_mul", {8'h00, mul_a0, mul_b0}, 16'h0000);
    check("midrst_busy", 16'(busy0), 16'd0);
    check("midrst_in_ready", 16'(in_ready0), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 16'(in_ready0), 16'd1);
    check("midrst_no_result", 16'(out_valid0), 16'd0);
    @(posedge clk);
    #1;
    send(8'h0A, 8'h0B, 16'h006E, 1'b1);
    drain();
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
